// File: rtl/wisc_pkg.sv
// Shared WISC-S15 definitions: opcodes, branch conditions,
// fetch FSM states and default datapath widths.
package wisc_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  localparam logic [3:0] ADD    = 4'h0;
  localparam logic [3:0] PADDSB = 4'h1;
  localparam logic [3:0] SUB    = 4'h2;
  localparam logic [3:0] AND    = 4'h3;
  localparam logic [3:0] NOR    = 4'h4;
  localparam logic [3:0] SLL    = 4'h5;
  localparam logic [3:0] SRL    = 4'h6;
  localparam logic [3:0] SRA    = 4'h7;
  localparam logic [3:0] LW     = 4'h8;
  localparam logic [3:0] SW     = 4'h9;
  localparam logic [3:0] LHB    = 4'hA;
  localparam logic [3:0] LLB    = 4'hB;
  localparam logic [3:0] BR     = 4'hC;
  localparam logic [3:0] CALL   = 4'hD;
  localparam logic [3:0] RET    = 4'hE;
  localparam logic [3:0] ERR    = 4'hF;

  localparam logic [2:0] EQ = 3'b000;
  localparam logic [2:0] NE = 3'b001;
  localparam logic [2:0] GT = 3'b010;
  localparam logic [2:0] LT = 3'b011;
  localparam logic [2:0] GE = 3'b100;
  localparam logic [2:0] LE = 3'b101;
  localparam logic [2:0] OV = 3'b110;
  localparam logic [2:0] TR = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    HALT
  } fetch_state_t;

  function automatic logic is_err(
    input logic [3:0] op
  );
    return op == ERR;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus: one request outstanding,
// data returned on rvalid some cycles after acceptance.
interface fetch_unit_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
) ();

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_rdy;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdy,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdy,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding buffer used when decode
// stalls while a fetch response is landing.
module fetch_skid_buf #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic               unload_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end else if (unload_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// WISC-S15 fetch stage: owns the PC, issues one imem read at a
// time, buffers up to two instructions, handles redirect/halt.
module fetch_unit
  import wisc_pkg::*;
#(
  parameter int               ADDR_W   = 16,
  parameter int               INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  fetch_unit_if.master       imem,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  pc_plus1,
  output logic               halted
);

  localparam logic [ADDR_W-1:0] ONE =
    {{(ADDR_W-1){1'b0}}, 1'b1};

  fetch_state_t state_q, state_d;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
  logic               kill_q, kill_d;
  logic               hpend_q, hpend_d;
  logic               ov_q, ov_d;
  logic [INSTR_W-1:0] oi_q, oi_d;
  logic [ADDR_W-1:0]  op_q, op_d;
  logic [ADDR_W-1:0]  op1_q, op1_d;

  logic               redir;
  logic               req;
  logic               accept;
  logic               consume;
  logic               deliver;
  logic               halt_take;
  logic               take_new;
  logic               sk_v;
  logic               sk_load;
  logic               sk_unload;
  logic [INSTR_W-1:0] sk_instr;
  logic [ADDR_W-1:0]  sk_pc;

  always_comb begin
    redir   = redirect_valid && (state_q != HALT);
    req     = (state_q == FETCH) && !sk_v && !hpend_q;
    accept  = req && imem.imem_rdy;
    consume = ov_q && !stall;
    deliver = (state_q == WAIT) && imem.imem_rvalid
              && !kill_q && !redir;
    halt_take = hpend_q && consume
                && is_err(oi_q[INSTR_W-1 -: 4]);
    sk_unload = consume && sk_v;
    take_new  = deliver && !sk_v && (!ov_q || consume);
    sk_load   = deliver && !take_new;
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = (state_q == FETCH) ? pc_q : '0;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    kill_d   = kill_q;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redir) pc_d = redirect_pc;
      end
      FETCH: begin
        if (redir) begin
          pc_d = redirect_pc;
          if (accept) begin
            kill_d  = 1'b1;
            state_d = WAIT;
          end
        end else if (halt_take) begin
          state_d = HALT;
        end else if (accept) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + ONE;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        // a response arriving with the redirect retires the
        // outstanding read, so no kill is needed for it
        if (redir) begin
          pc_d = redirect_pc;
          if (imem.imem_rvalid) begin
            kill_d  = 1'b0;
            state_d = FETCH;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem.imem_rvalid) begin
          kill_d  = 1'b0;
          state_d = FETCH;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    ov_d    = ov_q;
    oi_d    = oi_q;
    op_d    = op_q;
    op1_d   = op1_q;
    hpend_d = hpend_q;
    if (redir) begin
      ov_d    = 1'b0;
      hpend_d = 1'b0;
    end else begin
      if (sk_unload) begin
        ov_d  = 1'b1;
        oi_d  = sk_instr;
        op_d  = sk_pc;
        op1_d = sk_pc + ONE;
      end else if (take_new) begin
        ov_d  = 1'b1;
        oi_d  = imem.imem_rdata;
        op_d  = req_pc_q;
        op1_d = req_pc_q + ONE;
      end else if (consume) begin
        ov_d = 1'b0;
      end
      if (deliver
          && is_err(imem.imem_rdata[INSTR_W-1 -: 4]))
        hpend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      kill_q   <= 1'b0;
      hpend_q  <= 1'b0;
      ov_q     <= 1'b0;
      oi_q     <= '0;
      op_q     <= '0;
      op1_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      kill_q   <= kill_d;
      hpend_q  <= hpend_d;
      ov_q     <= ov_d;
      oi_q     <= oi_d;
      op_q     <= op_d;
      op1_q    <= op1_d;
    end
  end

  fetch_skid_buf #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (redir),
    .load_i   (sk_load),
    .unload_i (sk_unload),
    .instr_i  (imem.imem_rdata),
    .pc_i     (req_pc_q),
    .valid_o  (sk_v),
    .instr_o  (sk_instr),
    .pc_o     (sk_pc)
  );

  assign instr_valid = ov_q;
  assign instr       = oi_q;
  assign instr_pc    = op_q;
  assign pc_plus1    = op1_q;
  assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable
// instruction memory model on the slave side of the bus.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        rv;
  logic [15:0] rpc;
  logic        valid;
  logic [15:0] instr;
  logic [15:0] ipc;
  logic [15:0] pc1;
  logic        halted;

  int tests;
  int failed;

  logic [15:0] mem [0:65535];
  int          lat;
  logic        busy;
  int          cnt;
  logic [15:0] maddr;

  fetch_unit_if #(.ADDR_W(16), .INSTR_W(16)) bus ();

  fetch_unit #(
    .ADDR_W   (16),
    .INSTR_W  (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (rv),
    .redirect_pc    (rpc),
    .imem           (bus.master),
    .instr_valid    (valid),
    .instr          (instr),
    .instr_pc       (ipc),
    .pc_plus1       (pc1),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) begin
      busy             <= 1'b0;
      cnt              <= 0;
      maddr            <= '0;
      bus.imem_rvalid  <= 1'b0;
      bus.imem_rdata   <= '0;
    end else begin
      bus.imem_rvalid <= 1'b0;
      if (busy) begin
        if (cnt == 0) begin
          bus.imem_rvalid <= 1'b1;
          bus.imem_rdata  <= mem[maddr];
          busy            <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (bus.imem_req && bus.imem_rdy) begin
        if (lat == 0) begin
          bus.imem_rvalid <= 1'b1;
          bus.imem_rdata  <= mem[bus.imem_addr];
        end else begin
          busy  <= 1'b1;
          cnt   <= lat - 1;
          maddr <= bus.imem_addr;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " valid"}, 32'(valid), 0);
    chk({tag, " req"}, 32'(bus.imem_req), 0);
    chk({tag, " addr"}, 32'(bus.imem_addr), 0);
    chk({tag, " instr"}, 32'(instr), 0);
    chk({tag, " ipc"}, 32'(ipc), 0);
    chk({tag, " pc1"}, 32'(pc1), 0);
    chk({tag, " halted"}, 32'(halted), 0);
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    for (int i = 0; i < 65536; i++)
      mem[i] = {4'h2, i[11:0]};
    mem[0] = 16'h0123;
    mem[1] = 16'h1456;
    mem[5] = 16'hF000;
    rst_n = 1'b0;
    stall = 1'b0;
    rv    = 1'b0;
    rpc   = '0;
    lat   = 0;
    bus.imem_rdy = 1'b1;

    tick();
    tick();
    chk_zero("reset");
    rst_n = 1'b1;

    tick();
    chk("boot req", 32'(bus.imem_req), 1);
    chk("boot addr", 32'(bus.imem_addr), 16'h0000);
    tick();
    chk("wait req", 32'(bus.imem_req), 0);
    chk("pre valid", 32'(valid), 0);
    tick();
    chk("i0 valid", 32'(valid), 1);
    chk("i0 instr", 32'(instr), 16'h0123);
    chk("i0 pc", 32'(ipc), 16'h0000);
    chk("i0 pc1", 32'(pc1), 16'h0001);
    chk("addr1", 32'(bus.imem_addr), 16'h0001);
    tick();
    chk("i0 consumed", 32'(valid), 0);
    tick();
    chk("i1 instr", 32'(instr), 16'h1456);
    chk("i1 pc", 32'(ipc), 16'h0001);
    chk("addr2", 32'(bus.imem_addr), 16'h0002);

    tick();
    tick();
    chk("i2 instr", 32'(instr), 16'h2002);
    chk("i2 pc", 32'(ipc), 16'h0002);
    stall = 1'b1;
    tick();
    tick();
    chk("skid full req", 32'(bus.imem_req), 0);
    chk("stall instr", 32'(instr), 16'h2002);
    tick();
    tick();
    tick();
    chk("stall hold instr", 32'(instr), 16'h2002);
    chk("stall hold pc", 32'(ipc), 16'h0002);
    chk("stall hold valid", 32'(valid), 1);
    chk("stall hold req", 32'(bus.imem_req), 0);
    stall = 1'b0;
    tick();
    chk("skid instr", 32'(instr), 16'h2003);
    chk("skid pc", 32'(ipc), 16'h0003);
    chk("post skid req", 32'(bus.imem_req), 1);
    chk("post skid addr", 32'(bus.imem_addr), 16'h0004);
    tick();
    chk("i3 consumed", 32'(valid), 0);
    tick();
    chk("i4 instr", 32'(instr), 16'h2004);
    chk("i4 pc", 32'(ipc), 16'h0004);

    lat = 2;
    tick();
    chk("slow wait req", 32'(bus.imem_req), 0);
    rv  = 1'b1;
    rpc = 16'h0040;
    tick();
    rv  = 1'b0;
    lat = 0;
    chk("redir valid", 32'(valid), 0);
    chk("redir req", 32'(bus.imem_req), 0);
    tick();
    chk("kill wait req", 32'(bus.imem_req), 0);
    tick();
    chk("killed data", 32'(valid), 0);
    chk("redir req2", 32'(bus.imem_req), 1);
    chk("redir addr", 32'(bus.imem_addr), 16'h0040);
    tick();
    tick();
    chk("r40 valid", 32'(valid), 1);
    chk("r40 pc", 32'(ipc), 16'h0040);
    chk("r40 instr", 32'(instr), 16'h2040);

    stall = 1'b1;
    tick();
    rv  = 1'b1;
    rpc = 16'h0080;
    tick();
    rv    = 1'b0;
    stall = 1'b0;
    chk("rv+rvalid valid", 32'(valid), 0);
    chk("rv+rvalid req", 32'(bus.imem_req), 1);
    chk("rv+rvalid addr", 32'(bus.imem_addr), 16'h0080);
    tick();
    tick();
    chk("r80 pc", 32'(ipc), 16'h0080);
    chk("r80 instr", 32'(instr), 16'h2080);

    stall = 1'b1;
    tick();
    tick();
    chk("skid2 req", 32'(bus.imem_req), 0);
    rv  = 1'b1;
    rpc = 16'h00C0;
    tick();
    rv    = 1'b0;
    stall = 1'b0;
    chk("skid clr valid", 32'(valid), 0);
    chk("skid clr req", 32'(bus.imem_req), 1);
    chk("skid clr addr", 32'(bus.imem_addr), 16'h00C0);
    tick();
    tick();
    chk("rC0 pc", 32'(ipc), 16'h00C0);
    chk("rC0 instr", 32'(instr), 16'h20C0);

    rv  = 1'b1;
    rpc = 16'h0005;
    tick();
    rv = 1'b0;
    tick();
    chk("err addr", 32'(bus.imem_addr), 16'h0005);
    chk("err req", 32'(bus.imem_req), 1);
    tick();
    tick();
    chk("err instr", 32'(instr), 16'hF000);
    chk("err pc", 32'(ipc), 16'h0005);
    chk("err pend req", 32'(bus.imem_req), 0);
    chk("err pre halted", 32'(halted), 0);
    tick();
    chk("halted", 32'(halted), 1);
    chk("halt req", 32'(bus.imem_req), 0);
    chk("halt valid", 32'(valid), 0);
    rv  = 1'b1;
    rpc = 16'h0010;
    tick();
    tick();
    rv = 1'b0;
    chk("halt ign redir", 32'(halted), 1);
    chk("halt ign req", 32'(bus.imem_req), 0);

    rst_n = 1'b0;
    tick();
    chk("halt reset", 32'(halted), 0);
    chk("halt reset valid", 32'(valid), 0);
    rst_n = 1'b1;
    tick();
    chk("reboot req", 32'(bus.imem_req), 1);
    chk("reboot addr", 32'(bus.imem_addr), 16'h0000);
    rv  = 1'b1;
    rpc = 16'h0005;
    tick();
    rv = 1'b0;
    tick();
    chk("err2 addr", 32'(bus.imem_addr), 16'h0005);
    tick();
    tick();
    chk("err2 instr", 32'(instr), 16'hF000);
    stall = 1'b1;
    tick();
    chk("err2 pend req", 32'(bus.imem_req), 0);
    rv  = 1'b1;
    rpc = 16'h0020;
    tick();
    rv    = 1'b0;
    stall = 1'b0;
    chk("cancel halted", 32'(halted), 0);
    chk("cancel req", 32'(bus.imem_req), 1);
    chk("cancel addr", 32'(bus.imem_addr), 16'h0020);
    tick();
    tick();
    chk("r20 pc", 32'(ipc), 16'h0020);
    chk("r20 instr", 32'(instr), 16'h2020);
    chk("r20 halted", 32'(halted), 0);

    rv  = 1'b1;
    rpc = 16'hFFFF;
    tick();
    rv = 1'b0;
    tick();
    chk("top addr", 32'(bus.imem_addr), 16'hFFFF);
    tick();
    tick();
    chk("top pc", 32'(ipc), 16'hFFFF);
    chk("top instr", 32'(instr), 16'h2FFF);
    chk("top pc1", 32'(pc1), 16'h0000);
    chk("wrap addr", 32'(bus.imem_addr), 16'h0000);
    chk("wrap req", 32'(bus.imem_req), 1);

    lat = 3;
    tick();
    chk("mid wait req", 32'(bus.imem_req), 0);
    rst_n = 1'b0;
    tick();
    chk_zero("mid reset");
    rst_n = 1'b1;
    lat   = 0;
    tick();
    chk("restart req", 32'(bus.imem_req), 1);
    chk("restart addr", 32'(bus.imem_addr), 16'h0000);
    tick();
    tick();
    chk("restart instr", 32'(instr), 16'h0123);
    chk("restart pc", 32'(ipc), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
